uint8_window_mean: RTL and testbench

- Upstream feeder for the uint8.12-to-fp16 stage.
- Takes a valid-qualified stream of 8-bit unsigned samples and accumulates fixed-size windows of WINDOW samples.
- Emits one unsigned 8.12 fixed-point mean per window: 20 bits, 8 integer and 12 fraction.
- The output bus drops straight onto the converter's 20-bit uint8.12 input and its valid.

---
 rtl/uint8_12_pkg.sv | 31 +++
 rtl/uint8_12_scale.sv | 72 +++++++
 rtl/uint8_window_mean.sv | 165 ++++++++++++++++
 tb/tb_uint8_window_mean.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uint8_12_pkg.sv
// Shared definitions for the unsigned 8.12 fixed-point datapath: the bus
// type, its saturation value, the accumulator FSM states and the constant
// reciprocal used to turn a window sum into a mean.
package uint8_12_pkg;

    localparam int UINT8_12_WIDTH = 20;
    localparam int FRAC_BITS      = 12;

    typedef logic [UINT8_12_WIDTH-1:0] uint8_12_t;

    // Largest representable 8.12 value, used when a scaled result overflows.
    localparam uint8_12_t UINT8_12_MAX = '1;

    // Window accumulator states.
    typedef enum logic {
        ACC_EMPTY = 1'b0,
        ACC_ACCUM = 1'b1
    } acc_state_e;

    // round(2**(FRAC_BITS+shift) / window), i.e. 1/window expressed with
    // FRAC_BITS+shift fraction bits. Evaluated at elaboration time only.
    function automatic int unsigned recip_calc(input int unsigned window,
                                               input int unsigned shift);
        longint unsigned num;
        longint unsigned den;
        num = 64'd1 << (FRAC_BITS + int'(shift));
        den = 64'(window);
        return 32'((num + (den >> 1)) / den);
    endfunction

endpackage : uint8_12_pkg

// File: rtl/uint8_12_scale.sv
// Constant-reciprocal scaler: multiplies a window sum by a precomputed
// reciprocal, drops the extra reciprocal fraction bits (truncating) and
// saturates to the 8.12 range. One register stage; a drop marker travels
// alongside so it stays aligned with the mean pipeline.
module uint8_12_scale
    import uint8_12_pkg::*;
#(
    parameter int          SUM_WIDTH   = 12,
    parameter int unsigned RECIP       = 65536,
    parameter int          RECIP_SHIFT = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [SUM_WIDTH-1:0] sum_i,
    input  logic                 sum_valid_i,
    input  logic                 drop_i,
    output uint8_12_t            mean_o,
    output logic                 mean_valid_o,
    output logic                 drop_o
);

    localparam int RECIP_WIDTH = $clog2(RECIP + 1);
    localparam int PROD_WIDTH  = SUM_WIDTH + RECIP_WIDTH;
    // Work at least wide enough that bits above the 20-bit result exist after
    // the shift, so the overflow test below always has something to look at.
    localparam int EXT_WIDTH   = (PROD_WIDTH > RECIP_SHIFT + UINT8_12_WIDTH)
                               ? PROD_WIDTH
                               : RECIP_SHIFT + UINT8_12_WIDTH + 1;

    logic [EXT_WIDTH-1:0] prod;
    logic [EXT_WIDTH-1:0] shifted;
    uint8_12_t            mean_d;
    uint8_12_t            mean_q;
    logic                 mean_valid_d;
    logic                 mean_valid_q;
    logic                 drop_d;
    logic                 drop_q;

    // Multiply, truncate the reciprocal's extra fraction bits, then saturate.
    always_comb begin
        prod         = EXT_WIDTH'(sum_i) * EXT_WIDTH'(RECIP);
        shifted      = prod >> RECIP_SHIFT;
        mean_d       = mean_q;
        mean_valid_d = sum_valid_i;
        drop_d       = drop_i;
        if (sum_valid_i) begin
            if (|shifted[EXT_WIDTH-1:UINT8_12_WIDTH]) begin
                mean_d = UINT8_12_MAX;
            end else begin
                mean_d = shifted[UINT8_12_WIDTH-1:0];
            end
        end
    end

    // Stage register; the mean only moves when a new sum arrives.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mean_q       <= '0;
            mean_valid_q <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            mean_q       <= mean_d;
            mean_valid_q <= mean_valid_d;
            drop_q       <= drop_d;
        end
    end

    assign mean_o       = mean_q;
    assign mean_valid_o = mean_valid_q;
    assign drop_o       = drop_q;

endmodule : uint8_12_scale

// File: rtl/uint8_window_mean.sv
// Windowed mean of an 8-bit unsigned sample stream, emitted as uint8.12.
// Pipeline: input register -> window accumulator FSM -> constant-reciprocal
// scaler -> output register. A sof marker arriving mid-window abandons the
// partial window and raises a drop pulse through the same pipeline depth,
// so drop and mean pulses leave in the order their causes arrived.
module uint8_window_mean
    import uint8_12_pkg::*;
#(
    parameter int          WINDOW      = 16,
    parameter int          CNT_WIDTH   = $clog2(WINDOW + 1),
    parameter int          SUM_WIDTH   = 8 + $clog2(WINDOW),
    parameter int          RECIP_SHIFT = 8,
    parameter int unsigned RECIP       = recip_calc(WINDOW, RECIP_SHIFT)
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  sample_i,
    input  logic        valid_i,
    input  logic        sof_i,
    output uint8_12_t   mean_o,
    output logic        mean_valid_o,
    output logic        window_drop_o
);

    // A one-sample window would need to close on its opening sample, which
    // the accumulator does not handle; a 256-sample window is the widest the
    // reciprocal precision was sized for.
    if (WINDOW < 2 || WINDOW > 256) begin : g_bad_window
        $error("uint8_window_mean: WINDOW must lie in 2..256");
    end

    // Stage 0: registered inputs.
    logic [7:0]           sample_d, sample_q;
    logic                 valid_d, valid_q;
    logic                 sof_d, sof_q;

    // Stage 1: window accumulator.
    acc_state_e           state_d, state_q;
    logic [SUM_WIDTH-1:0] acc_d, acc_q;
    logic [CNT_WIDTH-1:0] count_d, count_q;
    logic                 sum_valid_d, sum_valid_q;
    logic                 drop_d, drop_q;

    // Stage 2: scaler outputs.
    uint8_12_t            scaled_mean;
    logic                 scaled_valid;
    logic                 scaled_drop;

    // Stage 3: output register.
    uint8_12_t            mean_d, mean_q;
    logic                 mean_valid_d, mean_valid_q;
    logic                 window_drop_d, window_drop_q;

    // Input capture: no backpressure, so every cycle is simply registered.
    always_comb begin
        sample_d = sample_i;
        valid_d  = valid_i;
        sof_d    = sof_i;
    end

    // Accumulator FSM: open a window, add samples, close on the WINDOW-th
    // sample, or abandon the partial window when sof arrives mid-window.
    // On close the full sum is left in acc_q for one cycle, which is exactly
    // when the scaler picks it up, even if the next window opens right away.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        sum_valid_d = 1'b0;
        drop_d      = 1'b0;
        if (valid_q) begin
            unique case (state_q)
                ACC_EMPTY: begin
                    acc_d   = SUM_WIDTH'(sample_q);
                    count_d = CNT_WIDTH'(1);
                    state_d = ACC_ACCUM;
                end
                ACC_ACCUM: begin
                    if (sof_q) begin
                        drop_d  = 1'b1;
                        acc_d   = SUM_WIDTH'(sample_q);
                        count_d = CNT_WIDTH'(1);
                    end else begin
                        acc_d   = acc_q + SUM_WIDTH'(sample_q);
                        count_d = count_q + CNT_WIDTH'(1);
                        if (count_q == CNT_WIDTH'(WINDOW - 1)) begin
                            sum_valid_d = 1'b1;
                            count_d     = '0;
                            state_d     = ACC_EMPTY;
                        end
                    end
                end
                default: begin
                    state_d = ACC_EMPTY;
                end
            endcase
        end
    end

    // Stage 0 and stage 1 state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sample_q    <= '0;
            valid_q     <= 1'b0;
            sof_q       <= 1'b0;
            state_q     <= ACC_EMPTY;
            acc_q       <= '0;
            count_q     <= '0;
            sum_valid_q <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            sample_q    <= sample_d;
            valid_q     <= valid_d;
            sof_q       <= sof_d;
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            sum_valid_q <= sum_valid_d;
            drop_q      <= drop_d;
        end
    end

    uint8_12_scale #(
        .SUM_WIDTH   (SUM_WIDTH),
        .RECIP       (RECIP),
        .RECIP_SHIFT (RECIP_SHIFT)
    ) u_scale (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .sum_i        (acc_q),
        .sum_valid_i  (sum_valid_q),
        .drop_i       (drop_q),
        .mean_o       (scaled_mean),
        .mean_valid_o (scaled_valid),
        .drop_o       (scaled_drop)
    );

    // Output stage: the mean holds its last value between pulses.
    always_comb begin
        mean_d        = mean_q;
        mean_valid_d  = scaled_valid;
        window_drop_d = scaled_drop;
        if (scaled_valid) begin
            mean_d = scaled_mean;
        end
    end

    // Output register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mean_q        <= '0;
            mean_valid_q  <= 1'b0;
            window_drop_q <= 1'b0;
        end else begin
            mean_q        <= mean_d;
            mean_valid_q  <= mean_valid_d;
            window_drop_q <= window_drop_d;
        end
    end

    assign mean_o        = mean_q;
    assign mean_valid_o  = mean_valid_q;
    assign window_drop_o = window_drop_q;

endmodule : uint8_window_mean

// File: tb/tb_uint8_window_mean.sv
// Self-checking bench for uint8_window_mean. A window-level reference model
// (running sum and sample count, exact mean arithmetic) predicts each mean
// and drop pulse together with the clock edge it must appear on.
module tb_uint8_window_mean;

    localparam int WIN = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  sample = '0;
    logic        valid = 1'b0;
    logic        sof = 1'b0;
    logic [19:0] mean;
    logic        mean_valid;
    logic        window_drop;

    logic [7:0]  sample3 = '0;
    logic        valid3 = 1'b0;
    logic        sof3 = 1'b0;
    logic [19:0] mean3;
    logic        mean_valid3;
    logic        window_drop3;

    uint8_window_mean dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .sample_i      (sample),
        .valid_i       (valid),
        .sof_i         (sof),
        .mean_o        (mean),
        .mean_valid_o  (mean_valid),
        .window_drop_o (window_drop)
    );

    uint8_window_mean #(
        .WINDOW      (3),
        .RECIP_SHIFT (8)
    ) dut3 (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .sample_i      (sample3),
        .valid_i       (valid3),
        .sof_i         (sof3),
        .mean_o        (mean3),
        .mean_valid_o  (mean_valid3),
        .window_drop_o (window_drop3)
    );

    always #5 clk = ~clk;

    // Count rising edges so expectations can name the exact edge they land on.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          edge_idx;
        logic [19:0] value;
    } mean_evt_t;

    mean_evt_t   mean_exp_q[$];
    int          drop_exp_q[$];
    int          model_count = 0;
    longint      model_sum = 0;
    logic [19:0] last_mean = '0;

    int compare_count = 0;
    int fail_count = 0;
    int mean_pulses = 0;
    int drop_pulses = 0;
    int last_pulse_cyc = 0;
    int prev_pulse_cyc = 0;

    function automatic logic [19:0] expected_mean(input longint sum, input int window);
        longint m;
        m = (sum * 4096) / window;
        if (m > 1048575) m = 1048575;
        return m[19:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        compare_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)",
                     tag, actual, expected, cyc);
        end
    endtask

    // Window-level model: a sof on a non-empty window drops it; the
    // WINDOW-th sample closes it. Both show up three edges later.
    task automatic modelAccept(input int edge_idx, input logic [7:0] s, input logic f);
        mean_evt_t evt;
        if (f && model_count > 0) begin
            drop_exp_q.push_back(edge_idx + 3);
            model_count = 0;
            model_sum   = 0;
        end
        model_sum   += longint'(s);
        model_count += 1;
        if (model_count == WIN) begin
            evt.edge_idx = edge_idx + 3;
            evt.value    = expected_mean(model_sum, WIN);
            mean_exp_q.push_back(evt);
            model_count = 0;
            model_sum   = 0;
        end
    endtask

    // Inputs change on the falling edge; the next rising edge samples them.
    task automatic applyStimulus(input logic [7:0] s, input logic v, input logic f);
        @(negedge clk);
        sample = s;
        valid  = v;
        sof    = f;
        if (v) modelAccept(cyc + 1, s, f);
    endtask

    task automatic waitDrain();
        applyStimulus(8'd0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            if (mean_exp_q.size() == 0 && drop_exp_q.size() == 0) break;
            @(negedge clk);
        end
        checkOutput("drainPending", 32'(mean_exp_q.size() + drop_exp_q.size()), 32'd0);
    endtask

    // Output monitor: every cycle, the pulse must be present exactly when
    // predicted and absent otherwise; the mean must hold between pulses.
    always @(negedge clk) begin
        if (mean_valid) begin
            prev_pulse_cyc = last_pulse_cyc;
            last_pulse_cyc = cyc;
            mean_pulses++;
        end
        if (window_drop) drop_pulses++;
        if (mean_exp_q.size() > 0 && mean_exp_q[0].edge_idx == cyc) begin
            checkOutput("meanValid", 32'(mean_valid), 32'd1);
            checkOutput("meanValue", 32'(mean), 32'(mean_exp_q[0].value));
            last_mean = mean_exp_q[0].value;
            void'(mean_exp_q.pop_front());
        end else begin
            checkOutput("meanValidIdle", 32'(mean_valid), 32'd0);
            checkOutput("meanHold", 32'(mean), 32'(last_mean));
        end
        if (drop_exp_q.size() > 0 && drop_exp_q[0] == cyc) begin
            checkOutput("dropPulse", 32'(window_drop), 32'd1);
            void'(drop_exp_q.pop_front());
        end else begin
            checkOutput("dropIdle", 32'(window_drop), 32'd0);
        end
    end

    initial begin
        int          drops_before;
        int          pulses_before;
        int          accepted;
        int          w3_edge;
        int          w3_seen;
        int          w3_sum;
        logic        w3_found;
        logic [7:0]  w3_vals [3];
        logic [7:0]  rs;
        logic        rv;

        // Reset state.
        repeat (3) @(negedge clk);
        checkOutput("resetMean", 32'(mean), 32'd0);
        checkOutput("resetMeanValid", 32'(mean_valid), 32'd0);
        checkOutput("resetDrop", 32'(window_drop), 32'd0);
        checkOutput("resetMean3", 32'(mean3), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full-scale window.
        $display("[TB] all-255 window");
        repeat (WIN) applyStimulus(8'd255, 1'b1, 1'b0);
        waitDrain();
        checkOutput("allMaxMean", 32'(mean), 32'hFF000);

        // Ramp window followed back-to-back by an all-ones window.
        $display("[TB] ramp then ones");
        for (int i = 0; i < WIN; i++) applyStimulus(8'(i), 1'b1, 1'b0);
        repeat (WIN) applyStimulus(8'd1, 1'b1, 1'b0);
        waitDrain();
        checkOutput("onesMean", 32'(mean), 32'h01000);
        checkOutput("pulseSpacing", 32'(last_pulse_cyc - prev_pulse_cyc), 32'(WIN));

        // Mid-window sof abandons the partial window.
        $display("[TB] sof mid-window");
        drops_before = drop_pulses;
        repeat (5) applyStimulus(8'd10, 1'b1, 1'b0);
        applyStimulus(8'd4, 1'b1, 1'b1);
        repeat (WIN - 1) applyStimulus(8'd4, 1'b1, 1'b0);
        waitDrain();
        checkOutput("dropCount", 32'(drop_pulses - drops_before), 32'd1);
        checkOutput("afterDropMean", 32'(mean), 32'h04000);

        // Three-sample window with a non-exact reciprocal.
        $display("[TB] window of 3");
        w3_vals[0] = 8'd1;
        w3_vals[1] = 8'd2;
        w3_vals[2] = 8'd2;
        w3_sum  = 0;
        w3_edge = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sample3 = w3_vals[i];
            valid3  = 1'b1;
            w3_edge = cyc + 1;
            w3_sum += int'(w3_vals[i]);
        end
        @(negedge clk);
        valid3   = 1'b0;
        w3_found = 1'b0;
        w3_seen  = 0;
        for (int i = 0; i < 10; i++) begin
            if (mean_valid3) begin
                w3_found = 1'b1;
                w3_seen  = cyc;
                break;
            end
            @(negedge clk);
        end
        checkOutput("w3Found", 32'(w3_found), 32'd1);
        checkOutput("w3Latency", 32'(w3_seen - w3_edge), 32'd3);
        checkOutput("w3Mean", 32'(mean3), 32'(expected_mean(longint'(w3_sum), 3)));

        // Asynchronous reset mid-window.
        $display("[TB] async reset mid-window");
        repeat (7) applyStimulus(8'd9, 1'b1, 1'b0);
        applyStimulus(8'd0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        model_count = 0;
        model_sum   = 0;
        mean_exp_q.delete();
        drop_exp_q.delete();
        last_mean = '0;
        #1;
        checkOutput("asyncResetMean", 32'(mean), 32'd0);
        checkOutput("asyncResetValid", 32'(mean_valid), 32'd0);
        checkOutput("asyncResetDrop", 32'(window_drop), 32'd0);
        pulses_before = mean_pulses;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (WIN) applyStimulus(8'd128, 1'b1, 1'b0);
        waitDrain();
        checkOutput("postResetMean", 32'(mean), 32'h80000);
        checkOutput("postResetPulses", 32'(mean_pulses - pulses_before), 32'd1);

        // Random samples with random gaps.
        $display("[TB] random stream with gaps");
        accepted      = 0;
        pulses_before = mean_pulses;
        for (int i = 0; i < 400; i++) begin
            rv = 1'($urandom_range(0, 1));
            rs = 8'($urandom_range(0, 255));
            applyStimulus(rs, rv, 1'b0);
            if (rv) accepted++;
        end
        waitDrain();
        checkOutput("randomPulseCount", 32'(mean_pulses - pulses_before), 32'(accepted / WIN));

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule : tb_uint8_window_mean
